// File: rtl/systolic_skew_buffer.sv
// systolic_skew_buffer: per-lane delay line feeding / draining a systolic PE array.
// Lane i is delayed BASE+i cycles (DIR=0, skew) or BASE+LANES-1-i cycles
// (DIR=1, deskew). Each stage carries a valid bit; en advances every lane,
// flush clears every stage, and occupancy counts valid stages in flight.
// Optional macro SKEW_ZERO_BUBBLE_EN: force dout lanes to zero when their
// out_valid bit is low, so bubbles present a MAC-neutral operand.
module systolic_skew_buffer #(
  parameter int LANES  = 16,
  parameter int DATA_W = 20,
  parameter int BASE   = 1,
  parameter int DIR    = 0,
  localparam int OCC_W = $clog2(LANES * (BASE + LANES) + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [LANES*DATA_W-1:0] din,
  output logic [LANES*DATA_W-1:0] dout,
  output logic [LANES-1:0]        out_valid,
  output logic                    busy,
  output logic [OCC_W-1:0]        occupancy
);

  localparam int TOTAL = LANES * BASE + (LANES * (LANES - 1)) / 2;

  // Delay of lane i in stages.
  function automatic int lane_depth(input int i);
    return (DIR == 0) ? (BASE + i) : (BASE + LANES - 1 - i);
  endfunction

  // Bit offset of lane i's valid bits inside the flat all-stage vector.
  function automatic int lane_offset(input int i);
    int s;
    s = 0;
    for (int k = 0; k < i; k++) s += lane_depth(k);
    return s;
  endfunction

  function automatic logic [OCC_W-1:0] count_lanes(input logic [LANES-1:0] v);
    logic [OCC_W-1:0] c;
    c = '0;
    for (int k = 0; k < LANES; k++) c += OCC_W'(v[k]);
    return c;
  endfunction

  function automatic logic [OCC_W-1:0] count_stages(input logic [TOTAL-1:0] v);
    logic [OCC_W-1:0] c;
    c = '0;
    for (int k = 0; k < TOTAL; k++) c += OCC_W'(v[k]);
    return c;
  endfunction

  logic [TOTAL-1:0]       w_all_vld;
  logic [LANES-1:0]       w_last_vld;
  logic [OCC_W-1:0]       w_occ_next;
  logic [OCC_W-1:0]       r_occ;
  logic                   r_rst_seen;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam int D   = lane_depth(g);
    localparam int OFF = lane_offset(g);

    logic [DATA_W-1:0] r_data [D];
    logic [D-1:0]      r_vld;

    // Shift this lane one stage on en; reset and flush empty it.
    always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
        r_vld <= '0;
        // NOTE: the data stages are cleared as well as the valid bits because
        // dout must read 0 after reset/flush even with zero-bubble disabled;
        // this is a register chain, not a RAM, so clearing it is cheap.
        for (int k = 0; k < D; k++) r_data[k] <= '0;
      end else if (en) begin
        // NOTE: non-blocking assignments make every stage read its
        // neighbour's pre-edge value, which is what turns this loop into a
        // shift rather than a single-cycle ripple through all stages.
        r_vld[0]  <= in_valid;
        r_data[0] <= din[g*DATA_W +: DATA_W];
        for (int k = 1; k < D; k++) begin
          r_vld[k]  <= r_vld[k-1];
          r_data[k] <= r_data[k-1];
        end
      end
    end

    assign w_all_vld[OFF +: D] = r_vld;
    assign w_last_vld[g]       = r_vld[D-1];
`ifdef SKEW_ZERO_BUBBLE_EN
    assign dout[g*DATA_W +: DATA_W] = r_vld[D-1] ? r_data[D-1] : '0;
`else
    assign dout[g*DATA_W +: DATA_W] = r_data[D-1];
`endif
  end

  // Next occupancy: a captured wavefront adds LANES, valid last stages leave.
  always_comb begin
    // NOTE: assigning a default first keeps this block purely combinational;
    // a path that left w_occ_next unassigned would infer a latch.
    w_occ_next = r_occ;
    if (en) begin
      w_occ_next = r_occ + (in_valid ? OCC_W'(LANES) : '0) - count_lanes(w_last_vld);
    end
  end

  // Occupancy register: cleared on reset or flush, frozen on stall.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) r_occ <= '0;
    else                   r_occ <= w_occ_next;
  end

  // Arm the occupancy invariant check once a reset has been applied.
  always_ff @(posedge clk) begin
    if (!reset_n) r_rst_seen <= 1'b1;
    if (reset_n && r_rst_seen) begin
      assert (r_occ == count_stages(w_all_vld))
        else $error("occupancy %0d disagrees with stage valid count %0d",
                    r_occ, count_stages(w_all_vld));
    end
  end

  assign out_valid = w_last_vld;
  assign busy      = |w_all_vld;
  assign occupancy = r_occ;

endmodule

// File: tb/tb_systolic_skew_buffer.sv
// Testbench for systolic_skew_buffer: drives a skew (DIR=0) and a deskew
// (DIR=1) instance with identical stimulus and compares both against a
// reference model built from the history of captured wavefronts.
module tb_systolic_skew_buffer;

  localparam int L     = 4;
  localparam int W     = 8;
  localparam int B     = 1;
  localparam int OCC_W = $clog2(L * (B + L) + 1);

  logic             clk;
  logic             reset_n;
  logic             en;
  logic             flush;
  logic             in_valid;
  logic [L*W-1:0]   din;

  logic [L*W-1:0]   dout0, dout1;
  logic [L-1:0]     ov0, ov1;
  logic             busy0, busy1;
  logic [OCC_W-1:0] occ0, occ1;

  systolic_skew_buffer #(.LANES(L), .DATA_W(W), .BASE(B), .DIR(0)) u_skew (
    .clk(clk), .reset_n(reset_n), .en(en), .flush(flush), .in_valid(in_valid),
    .din(din), .dout(dout0), .out_valid(ov0), .busy(busy0), .occupancy(occ0)
  );

  systolic_skew_buffer #(.LANES(L), .DATA_W(W), .BASE(B), .DIR(1)) u_deskew (
    .clk(clk), .reset_n(reset_n), .en(en), .flush(flush), .in_valid(in_valid),
    .din(din), .dout(dout1), .out_valid(ov1), .busy(busy1), .occupancy(occ1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic           v;
    logic [L*W-1:0] d;
  } cap_t;

  // Wavefronts captured since the last reset/flush, newest at the back.
  cap_t hist[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Expected outputs of one instance: lane i shows the wavefront captured
  // exactly depth(i) advances ago; occupancy counts valid wavefronts still
  // within each lane's depth window.
  task automatic check_dir(input int dir, input logic [L*W-1:0] a_dout,
                           input logic [L-1:0] a_ov, input logic a_busy,
                           input logic [OCC_W-1:0] a_occ);
    logic [L*W-1:0] e_dout;
    logic [L-1:0]   e_ov;
    int             e_occ;
    int             n;
    n      = hist.size();
    e_dout = '0;
    e_ov   = '0;
    e_occ  = 0;
    for (int i = 0; i < L; i++) begin
      int d;
      d = (dir == 0) ? (B + i) : (B + L - 1 - i);
      if (n >= d) begin
        e_ov[i] = hist[n-d].v;
        e_dout[i*W +: W] = hist[n-d].d[i*W +: W];
`ifdef SKEW_ZERO_BUBBLE_EN
        if (!hist[n-d].v) e_dout[i*W +: W] = '0;
`endif
      end
      for (int k = 1; k <= d; k++)
        if (n >= k && hist[n-k].v) e_occ++;
    end
    check($sformatf("dir%0d_dout", dir), 64'(a_dout), 64'(e_dout));
    check($sformatf("dir%0d_out_valid", dir), 64'(a_ov), 64'(e_ov));
    check($sformatf("dir%0d_busy", dir), 64'(a_busy), 64'(e_occ != 0));
    check($sformatf("dir%0d_occupancy", dir), 64'(a_occ), 64'(e_occ));
  endtask

  // One clock: update the model from the inputs seen at the edge, then
  // compare both instances half a cycle later.
  task automatic step();
    @(posedge clk);
    if (!reset_n || flush) hist.delete();
    else if (en) begin
      hist.push_back('{in_valid, din});
      if (hist.size() > B + L) void'(hist.pop_front());
    end
    cyc++;
    @(negedge clk);
    check_dir(0, dout0, ov0, busy0, occ0);
    check_dir(1, dout1, ov1, busy1, occ1);
  endtask

  task automatic drive(input logic r, input logic e, input logic f,
                       input logic v, input logic [L*W-1:0] d);
    reset_n  = r;
    en       = e;
    flush    = f;
    in_valid = v;
    din      = d;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    step();
    step();
    check("reset_occ_zero", 64'(occ0), 64'd0);

    // Single wavefront, continuous advance: staggered and mirrored arrival.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h44332211);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    for (int c = 1; c <= 5; c++) begin
      check("wf_occ_seq", 64'(occ0), 64'(4 - (c - 1)));
      check("wf_skew_ov", 64'(ov0), (c <= 4) ? 64'(4'b0001 << (c - 1)) : 64'd0);
      check("wf_deskew_ov", 64'(ov1), (c <= 4) ? 64'(4'b1000 >> (c - 1)) : 64'd0);
      if (c <= 4) check("wf_skew_lane", 64'(dout0[(c-1)*W +: W]), 64'(8'h11 * c));
      step();
    end

    // Stall for three cycles mid-flight.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h44332211);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D);
    for (int c = 0; c < 3; c++) begin
      check("stall_lane1", 64'(dout0[W +: W]), 64'h22);
      step();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    for (int c = 0; c < 5; c++) step();

    // Back-to-back wavefronts with a flush that also carries a valid input.
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b1, (c == 3), 1'b1, $urandom());
      step();
      if (c == 3) begin
        check("flush_occ", 64'(occ0), 64'd0);
        check("flush_dout", 64'(dout0), 64'd0);
      end
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    for (int c = 0; c < 5; c++) step();

    // Reset mid-flight, then a fresh wavefront.
    drive(1'b1, 1'b1, 1'b0, 1'b1, $urandom());
    step();
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b1, $urandom());
    step();
    check("midreset_busy", 64'(busy0), 64'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h44332211);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0);
    for (int c = 0; c < 5; c++) step();

    // Alternating valid/bubble wavefronts of all-ones data.
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 1'b1, 1'b0, c[0] == 1'b0, 32'hFFFFFFFF);
      step();
    end

    // Randomised traffic.
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 24) == 0), ($urandom_range(0, 9) < 6), $urandom());
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
